// File: rtl/conv2d_chan_accum.sv
// conv2d_chan_accum
// Sequential 3x3 convolution core for a single output channel.  One 3x3
// activation window and one 3x3 kernel are consumed per input channel per
// beat; the nine products are summed into a wide accumulator seeded with the
// bias.  After the last channel the accumulator is rescaled by 2^-Q and
// saturated to an N-bit signed fixed-point result.
//
// Optional build macro: CONV_RELU_EN
//   When defined, negative results are forced to zero after saturation.
//   out_sat still reports clipping that happened before the ReLU.
//
// Ports
//   clk         rising-edge clock
//   global_rst  synchronous active-high reset
//   cfg_cin     input-channel count, sampled on the first beat of a pixel
//   in_valid    window/kernel beat valid
//   in_ready    core can accept a beat
//   in_window   3x3 activations, element k at [k*N +: N], row-major
//   in_weight   3x3 kernel, same packing
//   in_bias     bias in Q format, sampled on the first beat of a pixel
//   out_valid   result valid
//   out_ready   downstream accepts result
//   out_data    saturated result in Q format
//   out_sat     result was clipped by saturation
module conv2d_chan_accum #(
    parameter int N     = 24,
    parameter int Q     = 13,
    parameter int C_MAX = 256
) (
    input  logic                       clk,
    input  logic                       global_rst,
    input  logic [$clog2(C_MAX+1)-1:0] cfg_cin,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [9*N-1:0]             in_window,
    input  logic [9*N-1:0]             in_weight,
    input  logic [N-1:0]               in_bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_sat
);

    localparam int ACC_W = 2*N + $clog2(9*C_MAX) + 1;
    localparam int CW    = $clog2(C_MAX+1);

    localparam logic [CW-1:0] CIN_MAX = CW'(C_MAX);
    localparam logic [CW-1:0] CIN_ONE = CW'(1);

    // Result range limits, sign-extended to accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]             ncin_q, ncin_d;
    logic [N-1:0]              out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic [CW-1:0]             cin_clamped;
    logic signed [2*N-1:0]     op_a, op_b, prod;
    logic signed [ACC_W-1:0]   beat_sum;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   res_shift;
    logic [N-1:0]              res_data;
    logic                      res_sat;

    // Channel-count clamp: 0 behaves as 1, anything above C_MAX as C_MAX.
    always_comb begin
        cin_clamped = cfg_cin;
        if (cfg_cin == '0) begin
            cin_clamped = CIN_ONE;
        end else if (cfg_cin > CIN_MAX) begin
            cin_clamped = CIN_MAX;
        end
    end

    // Nine full-width signed products summed at accumulator width.
    always_comb begin
        op_a     = '0;
        op_b     = '0;
        prod     = '0;
        beat_sum = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            op_a     = {{N{in_window[k*N+N-1]}}, in_window[k*N +: N]};
            op_b     = {{N{in_weight[k*N+N-1]}}, in_weight[k*N +: N]};
            prod     = op_a * op_b;
            beat_sum = beat_sum + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        end
    end

    assign bias_ext = {{(ACC_W-N){in_bias[N-1]}}, in_bias} <<< Q;

    // The first beat of a pixel seeds from the scaled bias instead of the
    // running total; the rescale/saturate path sees the post-beat value so
    // the result can be registered on the same edge as the final beat.
    assign acc_base = (state_q == ST_IDLE) ? bias_ext : acc_q;
    assign acc_sum  = acc_base + beat_sum;

    always_comb begin
        res_shift = acc_sum >>> Q;
        res_sat   = 1'b0;
        res_data  = res_shift[N-1:0];
        if (res_shift > SAT_MAX) begin
            res_data = SAT_MAX[N-1:0];
            res_sat  = 1'b1;
        end else if (res_shift < SAT_MIN) begin
            res_data = SAT_MIN[N-1:0];
            res_sat  = 1'b1;
        end
`ifdef CONV_RELU_EN
        if (res_data[N-1]) begin
            res_data = '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ncin_d     = ncin_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ncin_d = cin_clamped;
                    acc_d  = acc_sum;
                    cnt_d  = CIN_ONE;
                    if (cin_clamped == CIN_ONE) begin
                        state_d    = ST_OUT;
                        out_data_d = res_data;
                        out_sat_d  = res_sat;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CIN_ONE;
                    if (cnt_q == ncin_q - CIN_ONE) begin
                        state_d    = ST_OUT;
                        out_data_d = res_data;
                        out_sat_d  = res_sat;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ncin_q     <= CIN_ONE;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ncin_q     <= ncin_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign in_ready  = (state_q != ST_OUT);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv2d_chan_accum.sv
// Directed bench for conv2d_chan_accum (N=24, Q=13, C_MAX=256).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_conv2d_chan_accum;

    localparam int N     = 24;
    localparam int Q     = 13;
    localparam int C_MAX = 256;
    localparam int CW    = $clog2(C_MAX+1);

    logic            clk = 1'b0;
    logic            global_rst;
    logic [CW-1:0]   cfg_cin;
    logic            in_valid;
    logic            in_ready;
    logic [9*N-1:0]  in_window;
    logic [9*N-1:0]  in_weight;
    logic [N-1:0]    in_bias;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_data;
    logic            out_sat;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] held;

    always #5 clk = ~clk;

    conv2d_chan_accum #(.N(N), .Q(Q), .C_MAX(C_MAX)) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .cfg_cin    (cfg_cin),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_window  (in_window),
        .in_weight  (in_weight),
        .in_bias    (in_bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [N-1:0] w, input logic [N-1:0] k);
        in_window = {9{w}};
        in_weight = {9{k}};
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        global_rst = 1'b1;
        cfg_cin    = '0;
        in_valid   = 1'b0;
        in_window  = '0;
        in_weight  = '0;
        in_bias    = '0;
        out_ready  = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sat",   32'(out_sat),   32'd0);
        global_rst = 1'b0;

        // 1: single channel, 9 * 1.0 * 1.0 = 9.0
        cfg_cin = 9'd1; in_bias = '0; set_ops(24'd8192, 24'd8192);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid",    32'(out_valid), 32'd1);
        chk("t1_data",     32'(out_data),  32'h012000);
        chk("t1_sat",      32'(out_sat),   32'd0);
        chk("t1_in_ready", 32'(in_ready),  32'd0);
        step();
        chk("t1_done",     32'(out_valid), 32'd0);

        // 2: four channels back-to-back plus bias 1.0 = 37.0
        cfg_cin = 9'd4; in_bias = 24'd8192;
        in_valid = 1'b1;
        step(); step(); step();
        chk("t2_not_yet", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data",  32'(out_data),  32'h04A000);
        step();

        // gaps stall; mid-pixel cfg_cin/bias changes are ignored: 2 * 9.0 = 18.0
        cfg_cin = 9'd2; in_bias = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; cfg_cin = 9'd1; in_bias = 24'd8192;
        step(); step();
        chk("gap_stall", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_data",  32'(out_data),  32'h024000);
        step();

        // 3: saturation, both directions
        cfg_cin = 9'd2; in_bias = '0; set_ops(24'h7FFFFF, 24'h7FFFFF);
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        chk("t3p_data", 32'(out_data), 32'h7FFFFF);
        chk("t3p_sat",  32'(out_sat),  32'd1);
        step();
        set_ops(24'h7FFFFF, 24'h800000);
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
`ifdef CONV_RELU_EN
        chk("t3n_data", 32'(out_data), 32'h000000);
`else
        chk("t3n_data", 32'(out_data), 32'h800000);
`endif
        chk("t3n_sat",  32'(out_sat),  32'd1);
        step();

        // 4: back-pressure holds the result
        cfg_cin = 9'd1; in_bias = '0; set_ops(24'd8192, 24'd8192);
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        held = out_data;
        chk("t4_data0", 32'(held), 32'h012000);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_data",  32'(out_data),  32'(held));
            chk("t4_hold_ready", 32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t4_release_ready", 32'(in_ready),  32'd1);
        chk("t4_release_valid", 32'(out_valid), 32'd0);

        // 5: reset mid-pixel discards the partial sum
        cfg_cin = 9'd4; in_bias = 24'd8192;
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        global_rst = 1'b1;
        step();
        global_rst = 1'b0;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_ready", 32'(in_ready),  32'd1);
        chk("t5_rst_data",  32'(out_data),  32'd0);
        step(); step();
        chk("t5_no_output", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        step(); step(); step(); step();
        in_valid = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_data",  32'(out_data),  32'h04A000);
        step();

        // 6: negative result, ReLU-dependent
        cfg_cin = 9'd1; in_bias = '0; set_ops(24'd8192, 24'hFFE000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef CONV_RELU_EN
        chk("t6_data", 32'(out_data), 32'h000000);
`else
        chk("t6_data", 32'(out_data), 32'hFEE000);
`endif
        chk("t6_sat",  32'(out_sat),  32'd0);
        step();

        // cfg_cin=0 behaves as one channel
        cfg_cin = 9'd0; in_bias = '0; set_ops(24'd8192, 24'd8192);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("cin0_valid", 32'(out_valid), 32'd1);
        chk("cin0_data",  32'(out_data),  32'h012000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
